t07_esp_tx: RTL and testbench
=============================

# t07_esp_tx

Nibble-serial transmitter for the ESP link: accepts 32-bit words from the core through a valid/ready handshake, buffers them in a small FIFO, and drives them MSB-nibble-first onto a 4-bit parallel bus with a per-nibble valid strobe and a frame-start marker. It is the sending end of the same 4-bit ESP word protocol that `t07_top` receives on `ESP_in`, so words travel from the core to the ESP, or loop back into `ESP_in` for self-test.

## Interface
- `NIBBLE_HOLD`, 1: clock cycles each nibble is held on the bus (≥1).
- `GAP_CYCLES`, 0: idle cycles forced between consecutive words (≥0).
- `FIFO_DEPTH`, 4: word FIFO depth (power of two, ≥2).
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wdata_i`  in  32  word to transmit.
- `wvalid_i`  in  1  `wdata_i` is valid.
- `wready_o`  out  1  FIFO can accept a word. Equals `!fifo_full`.
- `ESP_out`  out  4  current nibble. Driven to 0 when not transmitting.
- `espValid`  out  1  `ESP_out` carries a valid nibble.
- `frameStart`  out  1  high during every hold cycle of nibble 0 (bits 31:28) of a word.
- `busy`  out  1  the FSM is not in IDLE, or the FIFO is non-empty.

## Operation
- Accept: a word is written to the FIFO on a rising edge where `wvalid_i && wready_o`. There is no bypass path: when the FIFO is full, `wready_o` is 0 even if a pop occurs on the same edge.
- FSM states are IDLE, SEND and GAP.
  - IDLE: outputs are 0. If the FIFO is non-empty, pop the head into shift register `sh`, clear `nib_idx` and `hold_cnt`, and go to SEND.
  - SEND: `ESP_out = sh[31:28]` and `espValid = 1`. `frameStart = (nib_idx == 0)`.
    - `hold_cnt` counts 0 to `NIBBLE_HOLD`-1. At the terminal count, shift `sh` left by 4, increment `nib_idx` and clear `hold_cnt`.
  - Word end: this is the terminal hold cycle with `nib_idx == 7`.
    - If `GAP_CYCLES > 0`, go to GAP.
    - Otherwise, if the FIFO is non-empty, pop the next word directly and stay in SEND (back-to-back, no bubble).
    - Otherwise, go to IDLE.
  - GAP: outputs are 0 for `GAP_CYCLES` cycles, then go to IDLE.
- Nibble order is bits 31:28 first and bits 3:0 last. Word 0xAABBCCDD is sent as A,A,B,B,C,C,D,D.
- `nib_idx` is 3 bits and wraps naturally from 7 to 0. `hold_cnt` width is $clog2(NIBBLE_HOLD)+1. FIFO pointers carry an extra wrap bit to distinguish full from empty.
- Reset, including mid-word: on the next edge the FIFO is flushed (both pointers 0), the FSM goes to IDLE and all counters and `sh` are cleared. Any partial word is dropped and is not resent.

## Timing
- Reset values: `ESP_out = 0`, `espValid = 0`, `frameStart = 0`, `busy = 0`, `wready_o = 1` from the first cycle after `rst` deasserts.
- All outputs are registered or derived from registered state only. No combinational path exists from `wvalid_i` or `wdata_i` to any output.
- Latency with an empty FIFO and FSM in IDLE:
  - Word accepted at edge N.
  - Pop at edge N+1.
  - First nibble is visible after edge N+1, i.e. a 2-edge latency.
- Word duration is 8×`NIBBLE_HOLD` cycles. With `GAP_CYCLES = 0` and data queued, the word period is exactly 8×`NIBBLE_HOLD` cycles.
- With `GAP_CYCLES = G > 0`, the word period is 8×`NIBBLE_HOLD` + G + 1 cycles, including the 1 cycle spent in IDLE.
- `busy` falls the cycle after the last nibble (or the last gap cycle), provided the FIFO is empty.

## Structure
- Shared package `t07_esp_pkg`:
  - `esp_tx_state_t` enum (IDLE, SEND, GAP).
  - `ESP_NIBBLES_PER_WORD = 8`, `ESP_NIBBLE_W = 4`, `ESP_WORD_W = 32`.
  - These are reused by the receiver.
- Sub-module `t07_esp_tx_fifo`: synchronous FIFO with parameter `DEPTH`, ports `push`/`pop`/`din`/`dout`/`full`/`empty`, and first-word-fall-through `dout`.
- The top module holds the FSM, the shift register and the counters.

## Test plan
- Reset then idle: assert `rst` for 2 cycles → all outputs 0, `wready_o = 1`, `busy = 0`. Hold idle 20 cycles → `espValid` stays 0.
- Single word, `NIBBLE_HOLD = 1`: push 0xAABBCCDD → 2 edges later `ESP_out` reads A,A,B,B,C,C,D,D on 8 consecutive cycles.
  - `frameStart` is high on the first nibble only.
  - Then outputs return to 0 and `busy = 0`.
- Back-to-back with FIFO fill: push 5 words 0x01234567…0x89ABCDEF as fast as `wready_o` allows, with `FIFO_DEPTH = 4` → `wready_o` drops when full.
  - All 40 nibbles are sent in order with no idle cycle.
  - `frameStart` pulses every 8 cycles.
- Hold and gap, `NIBBLE_HOLD = 4`, `GAP_CYCLES = 3`: push 0xAABBCCDD twice → each nibble lasts 4 cycles.
  - There are 3+1 zero cycles between words.
  - The second `frameStart` begins 36 cycles after the first.
- Reset mid-word: assert `rst` while transmitting nibble 3 of 0xDEADBEEF with 2 more words queued → next cycle outputs are 0 and the FIFO is empty.
  - Nothing is sent afterward until a new push.
- Loopback: feed `ESP_out` into `t07_top.ESP_in` and push 31 copies of 0xAABBCCDD → the receiver captures 31 words equal to 0xAABBCCDD.

Source files
------------

// File: rtl/t07_esp_pkg.sv
// Shared ESP link definitions: word/nibble geometry and the transmitter state encoding.
// The receiver side reuses the same constants.
package t07_esp_pkg;
    localparam int ESP_NIBBLES_PER_WORD = 8;
    localparam int ESP_NIBBLE_W         = 4;
    localparam int ESP_WORD_W           = 32;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP
    } esp_tx_state_t;
endpackage

// File: rtl/t07_esp_tx_fifo.sv
// Word FIFO in front of the ESP transmitter, with first-word-fall-through read data.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module t07_esp_tx_fifo
    import t07_esp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [ESP_WORD_W-1:0] din,
    output logic [ESP_WORD_W-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);

    logic [ESP_WORD_W-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (push && !full) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop && !empty) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign empty = (r_wr_ptr == r_rd_ptr);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];
endmodule

// File: rtl/t07_esp_tx.sv
// ESP nibble-serial transmitter: FIFO-buffered 32-bit words sent MSB nibble first,
// each nibble held NIBBLE_HOLD cycles, with an optional forced gap between words.
module t07_esp_tx
    import t07_esp_pkg::*;
#(
    parameter int NIBBLE_HOLD = 1,
    parameter int GAP_CYCLES  = 0,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ESP_WORD_W-1:0]   wdata_i,
    input  logic                    wvalid_i,
    output logic                    wready_o,
    output logic [ESP_NIBBLE_W-1:0] ESP_out,
    output logic                    espValid,
    output logic                    frameStart,
    output logic                    busy
);
    localparam int HOLD_W = $clog2(NIBBLE_HOLD) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NIBBLE_HOLD - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [2:0]        NIB_LAST  = 3'(ESP_NIBBLES_PER_WORD - 1);

    esp_tx_state_t           r_state;
    logic [ESP_WORD_W-1:0]   r_sh;
    logic [2:0]              r_nib_idx;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic [ESP_NIBBLE_W-1:0] r_esp_out;
    logic                    r_esp_valid;
    logic                    r_frame_start;

    logic                    w_full;
    logic                    w_empty;
    logic [ESP_WORD_W-1:0]   w_dout;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_hold_last;
    logic                    w_word_end;

    assign w_push      = wvalid_i && !w_full;
    assign w_hold_last = (r_hold_cnt == HOLD_LAST);
    assign w_word_end  = (r_state == SEND) && w_hold_last && (r_nib_idx == NIB_LAST);
    // Back-to-back pop at word end only when no gap is configured.
    assign w_pop       = !w_empty && ((r_state == IDLE) || (w_word_end && (GAP_CYCLES == 0)));

    t07_esp_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (wdata_i),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_sh          <= '0;
            r_nib_idx     <= '0;
            r_hold_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_esp_out     <= '0;
            r_esp_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_state       <= SEND;
                        r_sh          <= w_dout;
                        r_nib_idx     <= '0;
                        r_hold_cnt    <= '0;
                        r_esp_out     <= w_dout[ESP_WORD_W-1 -: ESP_NIBBLE_W];
                        r_esp_valid   <= 1'b1;
                        r_frame_start <= 1'b1;
                    end
                end
                SEND: begin
                    if (!w_hold_last) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else begin
                        r_hold_cnt    <= '0;
                        r_nib_idx     <= r_nib_idx + 1'b1;
                        r_sh          <= {r_sh[ESP_WORD_W-ESP_NIBBLE_W-1:0], {ESP_NIBBLE_W{1'b0}}};
                        r_esp_out     <= r_sh[ESP_WORD_W-ESP_NIBBLE_W-1 -: ESP_NIBBLE_W];
                        r_frame_start <= 1'b0;
                        if (r_nib_idx == NIB_LAST) begin
                            if (GAP_CYCLES > 0) begin
                                r_state     <= GAP;
                                r_gap_cnt   <= '0;
                                r_esp_out   <= '0;
                                r_esp_valid <= 1'b0;
                            end else if (w_pop) begin
                                r_sh          <= w_dout;
                                r_esp_out     <= w_dout[ESP_WORD_W-1 -: ESP_NIBBLE_W];
                                r_frame_start <= 1'b1;
                            end else begin
                                r_state     <= IDLE;
                                r_esp_out   <= '0;
                                r_esp_valid <= 1'b0;
                            end
                        end
                    end
                end
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) r_state   <= IDLE;
                    else                       r_gap_cnt <= r_gap_cnt + 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ESP_out    = r_esp_out;
    assign espValid   = r_esp_valid;
    assign frameStart = r_frame_start;
    assign wready_o   = !w_full;
    assign busy       = (r_state != IDLE) || !w_empty;
endmodule

// File: tb/tb_t07_esp_tx.sv
// Bench for t07_esp_tx: one instance with hold 1 / no gap, one with hold 4 / gap 3.
// Received nibbles are collected and compared with the word stream expanded from accepted words.
module tb_t07_esp_tx;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, rst1 = 1'b1;
    logic        wv0 = 1'b0, wv1 = 1'b0;
    logic [31:0] wd0 = '0, wd1 = '0;
    logic        wr0, v0, fs0, b0, wr1, v1, fs1, b1;
    logic [3:0]  n0, n1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    t07_esp_tx #(.NIBBLE_HOLD(1), .GAP_CYCLES(0), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst0), .wdata_i(wd0), .wvalid_i(wv0), .wready_o(wr0),
        .ESP_out(n0), .espValid(v0), .frameStart(fs0), .busy(b0));

    t07_esp_tx #(.NIBBLE_HOLD(4), .GAP_CYCLES(3), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst1), .wdata_i(wd1), .wvalid_i(wv1), .wready_o(wr1),
        .ESP_out(n1), .espValid(v1), .frameStart(fs1), .busy(b1));

    typedef struct packed {
        int         cyc;
        logic       fs;
        logic [3:0] nib;
    } obs_t;

    typedef struct {
        logic        rst;
        logic        wv;
        logic [31:0] wd;
        logic [7:0]  e;   // {wready, espValid, frameStart, busy, ESP_out}
    } vec_t;

    obs_t        obs0[$], obs1[$];
    logic [31:0] exp0[$], exp1[$], pend[$];
    obs_t        m0, m1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Receiver side: log every valid nibble, and require a quiet bus otherwise.
    always begin
        @(posedge clk);
        #1;
        if (v0) begin
            m0.cyc = cyc; m0.fs = fs0; m0.nib = n0;
            obs0.push_back(m0);
        end else chk("quiet0", {27'b0, fs0, n0}, 32'd0);
        if (v1) begin
            m1.cyc = cyc; m1.fs = fs1; m1.nib = n1;
            obs1.push_back(m1);
        end else chk("quiet1", {27'b0, fs1, n1}, 32'd0);
    end

    // Expected stream: each word gives 8 nibbles MSB first, each repeated hold times,
    // frameStart on nibble 0; when period > 0 words must start exactly period cycles apart.
    task automatic check_stream(input string name, input int which, input int hold, input int period);
        obs_t        o[$];
        logic [31:0] w[$];
        int          idx, t0, nb;
        if (which == 0) begin
            o = obs0; w = exp0; obs0.delete(); exp0.delete();
        end else begin
            o = obs1; w = exp1; obs1.delete(); exp1.delete();
        end
        chk({name, "_len"}, o.size(), w.size() * 8 * hold);
        if (o.size() != w.size() * 8 * hold || o.size() == 0) return;
        t0  = o[0].cyc;
        idx = 0;
        for (int k = 0; k < w.size(); k++) begin
            for (int j = 0; j < 8; j++) begin
                for (int h = 0; h < hold; h++) begin
                    nb = bad;
                    chk($sformatf("%s_w%0d_n%0d", name, k, j), {27'b0, o[idx].fs, o[idx].nib},
                        {27'b0, (j == 0), w[k][31 - 4 * j -: 4]});
                    if (period > 0)
                        chk($sformatf("%s_t%0d_n%0d", name, k, j), o[idx].cyc,
                            t0 + k * period + j * hold + h);
                    if (bad != nb) return;
                    idx++;
                end
            end
        end
    endtask

    task automatic push_pend(input int which);
        int guard = 0;
        while (pend.size() > 0 && guard < 200) begin
            @(negedge clk);
            if (which == 0) begin
                wv0 = 1'b1; wd0 = pend[0];
                if (wr0) exp0.push_back(pend.pop_front());
            end else begin
                wv1 = 1'b1; wd1 = pend[0];
                if (wr1) exp1.push_back(pend.pop_front());
            end
            guard++;
        end
        @(negedge clk);
        wv0 = 1'b0; wv1 = 1'b0;
        chk("push_timeout", pend.size(), 0);
        pend.delete();
    endtask

    task automatic wait_idle(input int which, input int budget);
        int k = 0;
        while (k < budget && ((which == 0) ? b0 : b1)) begin
            @(negedge clk);
            k++;
        end
        chk("drain_busy", (which == 0) ? b0 : b1, 0);
    endtask

    task automatic rand_run(input int which, input int n);
        logic        v;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            v = ($urandom_range(0, 2) != 0);
            d = $urandom;
            if (which == 0) begin
                wv0 = v; wd0 = d;
                if (v && wr0) exp0.push_back(d);
            end else begin
                wv1 = v; wd1 = d;
                if (v && wr1) exp1.push_back(d);
            end
        end
        @(negedge clk);
        wv0 = 1'b0; wv1 = 1'b0;
    endtask

    function automatic vec_t mkv(input logic r, input logic v, input logic [31:0] d, input logic [7:0] e);
        vec_t t;
        t.rst = r; t.wv = v; t.wd = d; t.e = e;
        return t;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[14];
        int   g;
        tbl[0]  = mkv(1, 0, 32'h0,        8'h80);
        tbl[1]  = mkv(1, 0, 32'h0,        8'h80);
        tbl[2]  = mkv(0, 0, 32'h0,        8'h80);
        tbl[3]  = mkv(0, 1, 32'hAABBCCDD, 8'h90);
        tbl[4]  = mkv(0, 0, 32'h0,        8'hFA);
        tbl[5]  = mkv(0, 0, 32'h0,        8'hDA);
        tbl[6]  = mkv(0, 0, 32'h0,        8'hDB);
        tbl[7]  = mkv(0, 0, 32'h0,        8'hDB);
        tbl[8]  = mkv(0, 0, 32'h0,        8'hDC);
        tbl[9]  = mkv(0, 0, 32'h0,        8'hDC);
        tbl[10] = mkv(0, 0, 32'h0,        8'hDD);
        tbl[11] = mkv(0, 0, 32'h0,        8'hDD);
        tbl[12] = mkv(0, 0, 32'h0,        8'h80);
        tbl[13] = mkv(0, 0, 32'h0,        8'h80);

        // Reset, single word and its 2-edge latency, cycle by cycle.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            rst0 = tbl[i].rst; rst1 = tbl[i].rst;
            wv0  = tbl[i].wv;  wd0  = tbl[i].wd;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), {24'b0, wr0, v0, fs0, b0, n0}, {24'b0, tbl[i].e});
        end
        chk("u1_reset_state", {24'b0, wr1, v1, fs1, b1, n1}, 32'h80);
        obs0.delete();

        repeat (20) @(negedge clk);
        chk("idle_quiet0", obs0.size(), 0);
        chk("idle_quiet1", obs1.size(), 0);

        // Back-to-back through a full FIFO.
        pend = '{32'h01234567, 32'h12345678, 32'h23456789, 32'h3456789A, 32'h89ABCDEF};
        push_pend(0);
        chk("b2b_wready_full", wr0, 0);
        wait_idle(0, 200);
        check_stream("b2b", 0, 1, 8);

        // Hold 4 and gap 3: words start 36 cycles apart.
        pend = '{32'hAABBCCDD, 32'hAABBCCDD};
        push_pend(1);
        wait_idle(1, 300);
        check_stream("holdgap", 1, 4, 36);

        // Reset during nibble 3 with two words still queued.
        pend = '{32'hDEADBEEF, 32'h11111111, 32'h22222222};
        push_pend(0);
        g = 0;
        while (obs0.size() < 4 && g < 30) begin
            @(negedge clk);
            g++;
        end
        chk("rstmid_reach", obs0.size(), 4);
        chk("rstmid_nibs", {16'b0, obs0[0].nib, obs0[1].nib, obs0[2].nib, obs0[3].nib}, 32'hDEAD);
        rst0 = 1'b1;
        @(posedge clk);
        #1;
        chk("rstmid_out", {24'b0, wr0, v0, fs0, b0, n0}, 32'h80);
        @(negedge clk);
        rst0 = 1'b0;
        obs0.delete();
        exp0.delete();
        repeat (20) @(negedge clk);
        chk("rstmid_silent", obs0.size(), 0);
        chk("rstmid_busy", b0, 0);

        // Random traffic with backpressure.
        rand_run(0, 300);
        wait_idle(0, 300);
        check_stream("rand0", 0, 1, 0);
        rand_run(1, 250);
        wait_idle(1, 600);
        check_stream("rand1", 1, 4, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
